// File: rtl/mult_block_reader.sv
// Block-read consumer: requests a burst from the multiplier and reduces it to sum, beat count and optional max.
// Define MULT_BLOCK_READER_MAX_EN to build the max tracker; otherwise max_val is tied to 0.
module mult_block_reader #(
    parameter int NUM_WORDS = 64,
    parameter int DATA_W    = 32,
    parameter int ACC_W     = 38,
    parameter int TIMEOUT   = 256
) (
    input  logic                           CLK,
    input  logic                           rst,
    input  logic                           EN_start,
    output logic                           RDY_start,
    output logic                           EN_blockRead,
    input  logic                           VALID_memVal,
    input  logic [DATA_W-1:0]              memVal_data,
    output logic                           VALID_result,
    output logic [ACC_W-1:0]               acc_sum,
    output logic [DATA_W-1:0]              max_val,
    output logic [$clog2(NUM_WORDS):0]     words_rcvd,
    output logic                           ERR_timeout
);

    localparam int WC_W = $clog2(NUM_WORDS) + 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

    state_t            state, state_nxt;
    logic [TO_W-1:0]   idle_cnt;
    logic              active, beat, last_beat, expired, start_acc;

    always_comb begin
        active    = (state == REQ) || (state == RECV);
        beat      = active && VALID_memVal;
        last_beat = beat && (words_rcvd == WC_W'(NUM_WORDS - 1));
        expired   = active && !VALID_memVal && (idle_cnt == TO_W'(TIMEOUT - 1));
        start_acc = (state == IDLE) && EN_start;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (EN_start) state_nxt = REQ;
            REQ: begin
                if (last_beat || expired) state_nxt = DONE;
                else if (beat)            state_nxt = RECV;
            end
            RECV: if (last_beat || expired) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decode the state register directly, so no input reaches them combinationally.
    always_comb begin
        RDY_start    = (state == IDLE);
        EN_blockRead = (state == REQ);
        VALID_result = (state == DONE);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            acc_sum     <= '0;
            words_rcvd  <= '0;
            ERR_timeout <= 1'b0;
            idle_cnt    <= '0;
        end else if (start_acc) begin
            acc_sum     <= '0;
            words_rcvd  <= '0;
            ERR_timeout <= 1'b0;
            idle_cnt    <= '0;
        end else if (beat) begin
            acc_sum     <= acc_sum + ACC_W'(memVal_data);
            words_rcvd  <= words_rcvd + 1'b1;
            idle_cnt    <= '0;
        end else if (active) begin
            idle_cnt    <= idle_cnt + 1'b1;
            if (expired) ERR_timeout <= 1'b1;
        end
    end

`ifdef MULT_BLOCK_READER_MAX_EN
    always_ff @(posedge CLK or posedge rst) begin
        if (rst)
            max_val <= '0;
        else if (start_acc)
            max_val <= '0;
        else if (beat && (memVal_data > max_val))
            max_val <= memVal_data;
    end
`else
    assign max_val = '0;
`endif

endmodule
